ats21_alarm_collector: RTL and testbench
========================================

Name: ats21_alarm_collector

Overview:
- Downstream consumer of the ATS21 alarm/timer outputs.
- Turns the 2-cycle "finished" pulses on the 24-bit alarm bus into a queue of discrete events; each event carries an alarm ID.
- Host drains events through a valid/ready handshake; irq is asserted while events or an overflow are outstanding.
- Sits between the ATS21 and the host/interrupt logic.

Parameters:
- NUM_ALARMS, 24, width of the alarm pulse bus.
- FIFO_DEPTH, 8, event queue entries; power of 2, at least 2.
- TS_WIDTH, 16, timestamp counter width (used only with the optional feature).
- ID_W, $clog2(NUM_ALARMS), event ID width (derived; not overridden).

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- alarm_in  input  NUM_ALARMS  alarm finished pulses (one bit per alarm)
- mask  input  NUM_ALARMS  1 = ignore rising edges on that bit
- clear  input  1  synchronous flush of queue, pending and overflow
- evt_valid  output  1  head-of-queue event is valid
- evt_ready  input  1  host accepts the head event
- evt_id  output  ID_W  alarm number of the head event
- evt_ts  output  TS_WIDTH  timestamp of the head event (0 when the feature is off)
- evt_count  output  $clog2(FIFO_DEPTH)+1  queue occupancy
- pending  output  NUM_ALARMS  captured edges not yet queued
- overflow  output  1  sticky: an event was merged or lost
- irq  output  1  evt_valid OR overflow

Behaviour:
- Reset state: all registers zero, including alarm_prev. Outputs: evt_valid=0, evt_id=0, evt_ts=0, evt_count=0, pending=0, overflow=0, irq=0.
- Edge detect:
  - alarm_prev <= alarm_in every cycle.
  - rise = alarm_in & ~alarm_prev & ~mask.
  - A 2-cycle pulse produces exactly one rise.
  - A bit already high when reset is released produces one rise on the first edge.
- Pending register: set on rise. Setting mask does not clear bits that are already pending.
- Arbiter, each cycle:
  - Selects the lowest-index set bit of the registered pending value.
  - Pushes it when evt_count < FIFO_DEPTH, or when the queue is full and a pop occurs in the same cycle.
  - Clears the pushed bit, unless a rise on the same bit occurs that cycle; then the bit stays set as a new event.
- Overflow: rise on a bit that is pending and not being pushed this cycle sets overflow (sticky). The two events merge into one.
- Latency: rise sampled at edge E0 → pending visible after E0 → push at E1 → evt_valid visible after E1. This is 2 cycles minimum with the queue not full.
- Queue:
  - Show-ahead FIFO; evt_valid = (evt_count != 0).
  - Pop on evt_valid & evt_ready; evt_ready is ignored when the queue is empty.
  - Simultaneous push and pop leave evt_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pushes per cycle: at most one. Backpressure is absorbed by pending, which holds at most one event per alarm.
- clear:
  - Empties the FIFO and zeroes pending and overflow.
  - Has priority over push, pop and rise in the same cycle.
  - alarm_prev still updates, so no spurious edge follows a clear.
- irq: combinational OR of the registered evt_valid and overflow.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); queued events are discarded.

Optional Feature:
- Macro: ATS21_EVT_TIMESTAMP_EN.
- Defined:
  - Free-running TS_WIDTH counter: reset 0, increments every cycle, wraps at all-ones.
  - On rise of bit i, ts_reg[i] captures the counter value at that edge.
  - On push, ts_reg[id] is stored with the ID.
  - evt_ts shows the head entry's timestamp.
  - On a merge (overflow), ts_reg[i] keeps the first timestamp.
- Undefined: no counter and no timestamp storage; evt_ts is tied to 0.

Test Plan:
- Reset, evt_ready=1, 2-cycle pulse on alarm_in[5] → one event id=5, evt_valid high for 1 cycle, 2 cycles after the rise; evt_count back to 0; no second event.
- evt_ready=0, simultaneous rises on bits 17, 3, 0 → evt_count reaches 3; then evt_ready=1 pops ids 0, 3, 17 in that order; irq drops after the last pop.
- evt_ready=0, 9 distinct bits (0–8) rise → evt_count=8, pending=0x000100. One pop → bit 8 pushed the next cycle, evt_count=8, pending=0.
- Queue full, bit 2 pending, second pulse on bit 2 → overflow=1, irq=1, only one id=2 event. Pulse clear → evt_count=0, pending=0, overflow=0, irq=0 next cycle.
- mask[7]=1, pulse on bit 7 → no event, pending[7]=0. Then mask[7]=0 with no new pulse → still no event.
- ATS21_EVT_TIMESTAMP_EN defined: rise on bit 4 sampled when counter=0x0010, ready held low 5 cycles → evt_id=4, evt_ts=0x0010. Counter wrap from 0xFFFF to 0x0000 is observed on a later event.

Source files
------------

// File: rtl/ats21_alarm_collector.sv
// Collects ATS21 alarm "finished" pulses into a show-ahead event queue drained by valid/ready, with irq.
// Optional feature macro ATS21_EVT_TIMESTAMP_EN: attaches a free-running timestamp to each event.
module ats21_alarm_collector #(
  parameter int NUM_ALARMS = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16,
  localparam int ID_W      = $clog2(NUM_ALARMS),
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_in,
  input  logic [NUM_ALARMS-1:0] mask,
  input  logic                  clear,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [ID_W-1:0]       evt_id,
  output logic [TS_WIDTH-1:0]   evt_ts,
  output logic [CW-1:0]         evt_count,
  output logic [NUM_ALARMS-1:0] pending,
  output logic                  overflow,
  output logic                  irq
);

  logic [NUM_ALARMS-1:0] alarm_prev;
  logic [NUM_ALARMS-1:0] rise;
  logic [NUM_ALARMS-1:0] pend_q;
  logic [NUM_ALARMS-1:0] push_oh;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       mem_id [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf_q;
  logic                  push;
  logic                  pop;

  assign rise = alarm_in & ~alarm_prev & ~mask;
  assign pop  = (count != '0) && evt_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = (pend_q != '0) && ((count < CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    sel_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_id = ID_W'(i);
    end
  end

  assign push_oh = push ? (NUM_ALARMS'(1) << sel_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_prev <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_id[i] <= '0;
    end else begin
      // Edge history tracks the input even through clear, so a clear never creates an edge.
      alarm_prev <= alarm_in;
      if (clear) begin
        pend_q <= '0;
        ovf_q  <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        pend_q <= (pend_q & ~push_oh) | rise;
        if ((rise & pend_q & ~push_oh) != '0) ovf_q <= 1'b1;
        if (push) begin
          mem_id[wr_ptr] <= sel_id;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef ATS21_EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_reg [NUM_ALARMS];
  logic [TS_WIDTH-1:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) ts_reg[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_ts[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (!clear) begin
        // A merged rise keeps the timestamp of the event already waiting.
        for (int i = 0; i < NUM_ALARMS; i++) begin
          if (rise[i] && !(pend_q[i] && !push_oh[i])) ts_reg[i] <= ts_cnt;
        end
        if (push) mem_ts[wr_ptr] <= ts_reg[sel_id];
      end
    end
  end

  assign evt_ts = mem_ts[rd_ptr];
`else
  assign evt_ts = '0;
`endif

  assign evt_valid = (count != '0);
  assign evt_id    = mem_id[rd_ptr];
  assign evt_count = count;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign irq       = evt_valid | ovf_q;

endmodule

// File: tb/tb_ats21_alarm_collector.sv
// Randomized and directed bench for ats21_alarm_collector against a queue-based event model.
// Define ATS21_EVT_TIMESTAMP_EN for both files to exercise timestamps.
module tb_ats21_alarm_collector;

  localparam int N = 24;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] alarm_in;
  logic [23:0] mask;
  logic        clear;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_id;
  logic [15:0] evt_ts;
  logic [3:0]  evt_count;
  logic [23:0] pending;
  logic        overflow;
  logic        irq;

  ats21_alarm_collector dut (
    .clk       (clk),
    .reset     (reset),
    .alarm_in  (alarm_in),
    .mask      (mask),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_ts    (evt_ts),
    .evt_count (evt_count),
    .pending   (pending),
    .overflow  (overflow),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  id;
    logic [15:0] ts;
  } ev_t;

  ev_t         m_q[$];
  logic [23:0] m_prev;
  logic [23:0] m_pend;
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic [15:0] m_ts [N];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = '0;
    m_pend = '0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
    for (int i = 0; i < N; i++) m_ts[i] = '0;
  endtask

  // One clock edge of the event-collector rules, applied to the model.
  task automatic model_step(input logic [23:0] a, input logic [23:0] m, input logic c, input logic r);
    logic [23:0] rise;
    logic [23:0] pushed;
    bit          pop;
    int          sel;
    ev_t         e;
    rise   = a & ~m_prev & ~m;
    pop    = (m_q.size() != 0) && r;
    pushed = '0;
    if (c) begin
      m_q.delete();
      m_pend = '0;
      m_ovf  = 1'b0;
    end else begin
      sel = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) sel = i;
      if (pop) void'(m_q.pop_front());
      if (sel >= 0 && m_q.size() < D) begin
        e.id = 5'(sel);
`ifdef ATS21_EVT_TIMESTAMP_EN
        e.ts = m_ts[sel];
`else
        e.ts = '0;
`endif
        m_q.push_back(e);
        pushed[sel] = 1'b1;
      end
      for (int j = 0; j < N; j++) begin
        if (rise[j]) begin
          if (m_pend[j] && !pushed[j]) m_ovf = 1'b1;
          else m_ts[j] = m_cnt;
        end
      end
      m_pend = (m_pend & ~pushed) | rise;
    end
    m_prev = a;
`ifdef ATS21_EVT_TIMESTAMP_EN
    m_cnt = m_cnt + 16'd1;
`endif
  endtask

  task automatic compare_all();
    check_eq("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    check_eq("evt_count", 32'(evt_count), 32'(m_q.size()));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("irq", 32'(irq), 32'((m_q.size() != 0) || m_ovf));
    if (m_q.size() != 0) begin
      check_eq("evt_id", 32'(evt_id), 32'(m_q[0].id));
      check_eq("evt_ts", 32'(evt_ts), 32'(m_q[0].ts));
    end
`ifndef ATS21_EVT_TIMESTAMP_EN
    else check_eq("evt_ts_off", 32'(evt_ts), 32'd0);
`endif
  endtask

  task automatic step(input logic [23:0] a, input logic [23:0] m, input logic c, input logic r);
    @(negedge clk);
    compare_all();
    alarm_in  = a;
    mask      = m;
    clear     = c;
    evt_ready = r;
    model_step(a, m, c, r);
  endtask

  task automatic pulse(input logic [23:0] bits, input logic [23:0] m, input logic r);
    step(bits, m, 1'b0, r);
    step(bits, m, 1'b0, r);
    step('0, m, 1'b0, r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, r);
  endtask

  // Asynchronous reset pulse between clock edges; inputs are left as they are.
  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_evt_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_evt_count", 32'(evt_count), 32'd0);
    check_eq("rst_evt_id", 32'(evt_id), 32'd0);
    check_eq("rst_evt_ts", 32'(evt_ts), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    #1 reset = 1'b0;
    model_step(alarm_in, mask, clear, evt_ready);
  endtask

  initial begin
    reset     = 1'b0;
    alarm_in  = '0;
    mask      = '0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    do_reset();

    // Single pulse drained immediately.
    pulse(24'h000020, '0, 1'b1);
    idle(4, 1'b1);

    // Simultaneous rises queue lowest index first.
    pulse(24'h020009, '0, 1'b0);
    idle(4, 1'b0);
    check_eq("three_queued", 32'(evt_count), 32'd3);
    idle(4, 1'b1);
    check_eq("irq_after_drain", 32'(irq), 32'd0);

    // Nine rises overfill the queue; the ninth waits in pending.
    pulse(24'h0001FF, '0, 1'b0);
    idle(10, 1'b0);
    check_eq("full_count", 32'(evt_count), 32'd8);
    check_eq("full_pending", 32'(pending), 32'h100);
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    check_eq("pop_push_count", 32'(evt_count), 32'd8);
    check_eq("pop_push_pending", 32'(pending), 32'd0);
    idle(12, 1'b1);

    // Merge on a pending bit while the queue is full, then clear.
    pulse(24'h00FF00, '0, 1'b0);
    idle(10, 1'b0);
    pulse(24'h000004, '0, 1'b0);
    idle(2, 1'b0);
    check_eq("bit2_pending", 32'(pending), 32'h4);
    pulse(24'h000004, '0, 1'b0);
    idle(1, 1'b0);
    check_eq("merge_overflow", 32'(overflow), 32'd1);
    check_eq("merge_irq", 32'(irq), 32'd1);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check_eq("clear_count", 32'(evt_count), 32'd0);
    check_eq("clear_pending", 32'(pending), 32'd0);
    check_eq("clear_overflow", 32'(overflow), 32'd0);
    check_eq("clear_irq", 32'(irq), 32'd0);

    // Masked pulse; unmasking while the input is still high must not produce an edge.
    step(24'h80, 24'h80, 1'b0, 1'b1);
    step(24'h80, 24'h80, 1'b0, 1'b1);
    step(24'h80, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    idle(3, 1'b1);
    check_eq("mask_pending", 32'(pending), 32'd0);
    check_eq("mask_count", 32'(evt_count), 32'd0);

`ifdef ATS21_EVT_TIMESTAMP_EN
    do_reset();
    while (m_cnt != 16'h0010) step('0, '0, 1'b0, 1'b0);
    pulse(24'h000010, '0, 1'b0);
    idle(5, 1'b0);
    check_eq("ts_id", 32'(evt_id), 32'd4);
    check_eq("ts_value", 32'(evt_ts), 32'h0010);
    idle(3, 1'b1);
    while (m_cnt != 16'hFFFA) step('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      pulse(24'h000200, '0, 1'b0);
      idle(1, 1'b0);
    end
    idle(6, 1'b1);
`endif

    // Randomized traffic with a clear now and then and an asynchronous reset midway.
    for (int i = 0; i < 3000; i++) begin
      logic [23:0] a;
      logic [23:0] m;
      logic        c;
      logic        r;
      a = 24'($urandom & $urandom & $urandom);
      m = 24'($urandom & $urandom & $urandom & $urandom);
      c = ($urandom_range(0, 99) == 0);
      r = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
      step(a, m, c, r);
    end
    idle(40, 1'b1);

    @(negedge clk);
    compare_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
